// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory path: address regions, load/store
// width encodings and the load/store unit state encoding.
package mem_pkg;

    localparam logic [15:0] REGION_ROM  = 16'h0000;
    localparam logic [15:0] REGION_MMIO = 16'h7000;
    localparam logic [15:0] REGION_RAM  = 16'h8000;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ls_funct3_t;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_PEND  = 2'd1,
        LSU_SPLIT = 2'd2
    } lsu_state_t;

    // An access is split when it spills into the next word; the memory
    // subsystem uses the same rule to decide when to raise dmem_wait.
    function automatic logic is_split(input logic [2:0] funct3, input logic [1:0] offset);
        logic half;
        logic word;
        half = (funct3[1:0] == 2'b01);
        word = (funct3[1:0] == 2'b10);
        return (half && (offset == 2'd3)) || (word && (offset != 2'd0));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of raw (LSB-aligned, zero-extended) load data by funct3.
module load_extend
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Select the extension rule for the access width and signedness.
    always_comb begin
        ext = raw;
        case (funct3)
            LS_B:    ext = {{24{raw[7]}}, raw[7:0]};
            LS_H:    ext = {{16{raw[15]}}, raw[15:0]};
            LS_W:    ext = raw;
            LS_BU:   ext = {24'h0, raw[7:0]};
            LS_HU:   ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Front end of the data-memory port: issues one access per cycle, tracks the
// single outstanding access (including split-access stalls) and returns
// extended load data, store completion or an access fault.
module load_store_unit
    import mem_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter bit CHECK_REGIONS    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] dmem_address,
    output logic        dmem_enable,
    output logic [31:0] dmem_write_data,
    output logic        dmem_write_enable,
    output logic [2:0]  dmem_write_mode,
    output logic        dmem_read_enable,
    output logic [2:0]  dmem_read_mode,
    input  logic [31:0] dmem_read_data,
    input  logic        dmem_wait
);

    lsu_state_t  state_q;
    logic        is_load_q;
    logic [2:0]  funct3_q;
    logic        fault_q;

    logic        req_fault;
    logic        accepted;
    logic        issue;
    logic [31:0] ext_data;

    // Classify the incoming request; a faulting request never reaches memory.
    always_comb begin
        logic [15:0] region;
        logic [1:0]  offset;
        logic        half;
        logic        word;
        logic        bad_funct3;
        logic        bad_region;
        logic        rom_store;
        logic        crosses_64k;
        logic        misaligned;
        region      = req_addr[31:16];
        offset      = req_addr[1:0];
        half        = (req_funct3[1:0] == 2'b01);
        word        = (req_funct3[1:0] == 2'b10);
        bad_funct3  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                      (req_write && req_funct3[2]);
        bad_region  = CHECK_REGIONS && !((region == REGION_ROM) ||
                                         (region == REGION_MMIO) ||
                                         (region == REGION_RAM));
        rom_store   = CHECK_REGIONS && req_write && (region == REGION_ROM);
        crosses_64k = (&req_addr[15:2]) && is_split(req_funct3, offset);
        misaligned  = !ALLOW_MISALIGNED && ((half && offset[0]) || (word && (offset != 2'd0)));
        req_fault   = bad_funct3 || bad_region || rom_store || crosses_64k || misaligned;
    end

    // No request is taken during reset or while memory finishes a split access.
    always_comb begin
        req_ready = reset_n && !dmem_wait;
        accepted  = req_valid && req_ready;
        issue     = accepted && !req_fault;
    end

    // Drive the memory request in the same cycle the request is accepted.
    always_comb begin
        dmem_enable       = issue;
        dmem_address      = issue ? req_addr : 32'h0;
        dmem_write_enable = issue && req_write;
        dmem_write_data   = (issue && req_write) ? req_wdata : 32'h0;
        dmem_write_mode   = (issue && req_write) ? req_funct3 : 3'b000;
        dmem_read_enable  = issue && !req_write;
        dmem_read_mode    = (issue && !req_write) ? req_funct3 : 3'b000;
    end

    load_extend u_load_extend (
        .funct3 (funct3_q),
        .raw    (dmem_read_data),
        .ext    (ext_data)
    );

    // Respond when the outstanding access completes; stores and faults return 0.
    always_comb begin
        resp_valid = reset_n && (((state_q == LSU_PEND) && !dmem_wait) || (state_q == LSU_SPLIT));
        resp_fault = resp_valid && fault_q;
        resp_rdata = (resp_valid && is_load_q && !fault_q) ? ext_data : 32'h0;
    end

    // Access tracking FSM plus the per-access attributes needed at response time.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= LSU_IDLE;
            is_load_q <= 1'b0;
            funct3_q  <= 3'b000;
            fault_q   <= 1'b0;
        end else begin
            if (accepted) begin
                is_load_q <= !req_write;
                funct3_q  <= req_funct3;
                fault_q   <= req_fault;
            end
            case (state_q)
                LSU_IDLE:  state_q <= accepted ? LSU_PEND : LSU_IDLE;
                LSU_PEND:  begin
                    if (dmem_wait)
                        state_q <= LSU_SPLIT;
                    else
                        state_q <= accepted ? LSU_PEND : LSU_IDLE;
                end
                LSU_SPLIT: state_q <= accepted ? LSU_PEND : LSU_IDLE;
                default:   state_q <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; the bench plays the memory subsystem by
// driving merged read data and dmem_wait with hand-computed values.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] dmem_read_data;
    logic        dmem_wait;

    logic        req_ready, resp_valid, resp_fault;
    logic [31:0] resp_rdata, dmem_address, dmem_write_data;
    logic        dmem_enable, dmem_write_enable, dmem_read_enable;
    logic [2:0]  dmem_write_mode, dmem_read_mode;

    logic        na_req_ready, na_resp_valid, na_resp_fault;
    logic [31:0] na_resp_rdata, na_dmem_address, na_dmem_write_data;
    logic        na_dmem_enable, na_dmem_write_enable, na_dmem_read_enable;
    logic [2:0]  na_dmem_write_mode, na_dmem_read_mode;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .dmem_address(dmem_address), .dmem_enable(dmem_enable),
        .dmem_write_data(dmem_write_data), .dmem_write_enable(dmem_write_enable),
        .dmem_write_mode(dmem_write_mode), .dmem_read_enable(dmem_read_enable),
        .dmem_read_mode(dmem_read_mode), .dmem_read_data(dmem_read_data),
        .dmem_wait(dmem_wait)
    );

    load_store_unit #(.ALLOW_MISALIGNED(1'b0), .CHECK_REGIONS(1'b1)) dut_na (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(na_req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(na_resp_valid), .resp_rdata(na_resp_rdata), .resp_fault(na_resp_fault),
        .dmem_address(na_dmem_address), .dmem_enable(na_dmem_enable),
        .dmem_write_data(na_dmem_write_data), .dmem_write_enable(na_dmem_write_enable),
        .dmem_write_mode(na_dmem_write_mode), .dmem_read_enable(na_dmem_read_enable),
        .dmem_read_mode(na_dmem_read_mode), .dmem_read_data(dmem_read_data),
        .dmem_wait(dmem_wait)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic drive_idle();
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
    endtask

    initial begin
        reset_n        = 1'b0;
        dmem_wait      = 1'b0;
        dmem_read_data = 32'h0;
        drive_req(1'b0, 3'b010, 32'h80000010, 32'h0);

        // Reset: every output held at 0 even with a valid request present.
        next_cycle();
        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_dmem_enable", {31'h0, dmem_enable}, 32'h0);
        chk("rst_dmem_address", dmem_address, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        next_cycle();
        reset_n = 1'b1;
        drive_idle();

        // 1. LB @0x80000013 of word 0x80FF7F01 -> byte 0x80.
        next_cycle();
        drive_req(1'b0, 3'b000, 32'h80000013, 32'h0);
        #1;
        chk("lb_ready", {31'h0, req_ready}, 32'h1);
        chk("lb_dmem_enable", {31'h0, dmem_enable}, 32'h1);
        chk("lb_dmem_read_enable", {31'h0, dmem_read_enable}, 32'h1);
        chk("lb_dmem_address", dmem_address, 32'h80000013);
        chk("lb_dmem_read_mode", {29'h0, dmem_read_mode}, 32'h0);
        chk("lb_no_early_resp", {31'h0, resp_valid}, 32'h0);
        next_cycle();
        drive_idle();
        dmem_read_data = 32'h00000080;
        #1;
        chk("lb_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("lb_rdata", resp_rdata, 32'hFFFFFF80);
        chk("lb_fault", {31'h0, resp_fault}, 32'h0);

        next_cycle();
        drive_req(1'b0, 3'b100, 32'h80000013, 32'h0);
        #1;
        chk("lbu_read_mode", {29'h0, dmem_read_mode}, 32'h4);
        next_cycle();
        drive_idle();
        dmem_read_data = 32'h00000080;
        #1;
        chk("lbu_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("lbu_rdata", resp_rdata, 32'h00000080);

        next_cycle();
        drive_req(1'b0, 3'b001, 32'h80000010, 32'h0);
        next_cycle();
        drive_idle();
        dmem_read_data = 32'h00007F01;
        #1;
        chk("lh_rdata", resp_rdata, 32'h00007F01);

        // 2. Split LW @0x80000012 -> wait at N+1, response at N+2.
        next_cycle();
        drive_req(1'b0, 3'b010, 32'h80000012, 32'h0);
        #1;
        chk("split_dmem_enable", {31'h0, dmem_enable}, 32'h1);
        next_cycle();
        dmem_wait = 1'b1;
        dmem_read_data = 32'h0;
        drive_req(1'b0, 3'b010, 32'h80000040, 32'h0);
        #1;
        chk("split_ready_low", {31'h0, req_ready}, 32'h0);
        chk("split_no_resp", {31'h0, resp_valid}, 32'h0);
        chk("split_dmem_quiet", {31'h0, dmem_enable}, 32'h0);
        chk("split_addr_quiet", dmem_address, 32'h0);
        next_cycle();
        dmem_wait = 1'b0;
        drive_idle();
        dmem_read_data = 32'h66554433;
        #1;
        chk("split_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("split_rdata", resp_rdata, 32'h66554433);
        next_cycle();
        dmem_read_data = 32'h0;
        #1;
        chk("split_done_idle", {31'h0, resp_valid}, 32'h0);

        // 3. SW then LW back-to-back: responses on consecutive cycles.
        drive_req(1'b1, 3'b010, 32'h80000020, 32'hDEADBEEF);
        #1;
        chk("sw_write_enable", {31'h0, dmem_write_enable}, 32'h1);
        chk("sw_write_data", dmem_write_data, 32'hDEADBEEF);
        chk("sw_write_mode", {29'h0, dmem_write_mode}, 32'h2);
        chk("sw_read_enable", {31'h0, dmem_read_enable}, 32'h0);
        next_cycle();
        drive_req(1'b0, 3'b010, 32'h80000020, 32'h0);
        #1;
        chk("sw_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("sw_resp_rdata", resp_rdata, 32'h0);
        chk("b2b_lw_issue", {31'h0, dmem_read_enable}, 32'h1);
        next_cycle();
        drive_idle();
        dmem_read_data = 32'hDEADBEEF;
        #1;
        chk("b2b_lw_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("b2b_lw_rdata", resp_rdata, 32'hDEADBEEF);

        // 4. Faults: ROM store, unmapped region, illegal funct3.
        next_cycle();
        drive_req(1'b1, 3'b010, 32'h00000100, 32'h12345678);
        #1;
        chk("rom_sw_no_enable", {31'h0, dmem_enable}, 32'h0);
        next_cycle();
        drive_req(1'b0, 3'b010, 32'h12340000, 32'h0);
        dmem_read_data = 32'hA5A5A5A5;
        #1;
        chk("rom_sw_fault", {31'h0, resp_fault}, 32'h1);
        chk("rom_sw_rdata", resp_rdata, 32'h0);
        chk("region_no_enable", {31'h0, dmem_enable}, 32'h0);
        next_cycle();
        drive_req(1'b0, 3'b011, 32'h80000000, 32'h0);
        #1;
        chk("region_fault", {31'h0, resp_fault}, 32'h1);
        chk("region_rdata", resp_rdata, 32'h0);
        chk("f3_no_enable", {31'h0, dmem_enable}, 32'h0);
        next_cycle();
        drive_idle();
        #1;
        chk("f3_fault_valid", {31'h0, resp_valid}, 32'h1);
        chk("f3_fault", {31'h0, resp_fault}, 32'h1);
        chk("f3_rdata", resp_rdata, 32'h0);

        // 5. 64 KiB crossing faults; misaligned half faults only without split support.
        next_cycle();
        drive_req(1'b0, 3'b010, 32'h8000FFFE, 32'h0);
        #1;
        chk("cross_no_enable", {31'h0, dmem_enable}, 32'h0);
        next_cycle();
        drive_req(1'b0, 3'b001, 32'h80000001, 32'h0);
        #1;
        chk("cross_fault", {31'h0, resp_fault}, 32'h1);
        chk("lh_mis_main_enable", {31'h0, dmem_enable}, 32'h1);
        chk("lh_mis_na_enable", {31'h0, na_dmem_enable}, 32'h0);
        next_cycle();
        drive_idle();
        dmem_read_data = 32'h00001234;
        #1;
        chk("lh_mis_main_fault", {31'h0, resp_fault}, 32'h0);
        chk("lh_mis_main_rdata", resp_rdata, 32'h00001234);
        chk("lh_mis_na_fault", {31'h0, na_resp_fault}, 32'h1);
        chk("lh_mis_na_rdata", na_resp_rdata, 32'h0);

        // 6. Reset right after a split LW is issued drops the access.
        next_cycle();
        dmem_read_data = 32'h0;
        drive_req(1'b0, 3'b010, 32'h80000012, 32'h0);
        next_cycle();
        drive_idle();
        reset_n = 1'b0;
        dmem_wait = 1'b1;
        #1;
        chk("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_mid_fault", {31'h0, resp_fault}, 32'h0);
        chk("rst_mid_rdata", resp_rdata, 32'h0);
        next_cycle();
        reset_n = 1'b1;
        dmem_wait = 1'b0;
        dmem_read_data = 32'h11111111;
        #1;
        chk("rst_after_no_resp", {31'h0, resp_valid}, 32'h0);
        next_cycle();
        drive_req(1'b0, 3'b010, 32'h80000010, 32'h0);
        #1;
        chk("post_rst_enable", {31'h0, dmem_enable}, 32'h1);
        next_cycle();
        drive_idle();
        dmem_read_data = 32'h44332211;
        #1;
        chk("post_rst_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("post_rst_rdata", resp_rdata, 32'h44332211);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
